alu_ctrl_stage: RTL

Decode-side producer of the ALU control interface for the RV32I 5-stage pipeline. It takes a fetched instruction in ID together with register-file operands and the PC. It decodes the opcode, funct3 and funct7 fields into the 4-bit ALU control code and two 32-bit operands, then registers them into the ID/EX pipeline register under stall and flush control. EX feeds its outputs directly to the ALU and branch logic.

---
 rtl/alu_ctrl_stage.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - RV32I ID-side ALU control decode and ID/EX register
module alu_ctrl_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_alucontrol,
  output logic [31:0] ex_srca,
  output logic [31:0] ex_srcb,
  output logic [31:0] ex_store_data,
  output logic        ex_is_branch,
  output logic [2:0]  ex_funct3,
  output logic        ex_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_u;
  logic [31:0] w_shamt;
  logic        w_alt;
  logic [3:0]  w_f3_alu;

  logic        w_illegal;
  logic [3:0]  w_alu;
  logic [31:0] w_srca;
  logic [31:0] w_srcb;
  logic [31:0] w_store_data;
  logic        w_is_branch;

  logic        r_valid;
  logic [3:0]  r_alucontrol;
  logic [31:0] r_srca;
  logic [31:0] r_srcb;
  logic [31:0] r_store_data;
  logic        r_is_branch;
  logic [2:0]  r_funct3;
  logic        r_illegal;

  assign w_opcode = id_instr[6:0];
  assign w_funct3 = id_instr[14:12];
  assign w_funct7 = id_instr[31:25];
  assign w_imm_i  = {{20{id_instr[31]}}, id_instr[31:20]};
  assign w_imm_s  = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign w_imm_u  = {id_instr[31:12], 12'b0};
  // Shift immediates carry only the shamt so funct7 bits never reach the ALU
  assign w_shamt  = {27'b0, id_instr[24:20]};
  assign w_alt    = (w_funct7 == F7_ALT);

  // Shared funct3 map for R-type and I-ALU; w_alt selects sub/sra
  always_comb begin
    w_f3_alu = ALU_ADD;
    case (w_funct3)
      3'b000:  w_f3_alu = w_alt ? ALU_SUB : ALU_ADD;
      3'b001:  w_f3_alu = ALU_SLL;
      3'b010:  w_f3_alu = ALU_SLT;
      3'b011:  w_f3_alu = ALU_SLTU;
      3'b100:  w_f3_alu = ALU_XOR;
      3'b101:  w_f3_alu = w_alt ? ALU_SRA : ALU_SRL;
      3'b110:  w_f3_alu = ALU_OR;
      default: w_f3_alu = ALU_AND;
    endcase
  end

  // Opcode decode into ALU code and operands; illegal decodes zero the payload
  always_comb begin
    w_illegal    = 1'b0;
    w_alu        = ALU_ADD;
    w_srca       = 32'b0;
    w_srcb       = 32'b0;
    w_store_data = 32'b0;
    w_is_branch  = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_srca = id_rs1_data;
        w_srcb = id_rs2_data;
        w_alu  = w_f3_alu;
        if (!(w_funct7 == F7_ZERO ||
              (w_alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101))))
          w_illegal = 1'b1;
      end
      OP_I: begin
        w_srca = id_rs1_data;
        w_srcb = w_imm_i;
        w_alu  = w_f3_alu;
        if (w_funct3 == 3'b000) begin
          w_alu = ALU_ADD;
        end else if (w_funct3 == 3'b001) begin
          w_srcb = w_shamt;
          if (w_funct7 != F7_ZERO) w_illegal = 1'b1;
        end else if (w_funct3 == 3'b101) begin
          w_srcb = w_shamt;
          if (!(w_funct7 == F7_ZERO || w_alt)) w_illegal = 1'b1;
        end
      end
      OP_LOAD, OP_JALR: begin
        w_srca = id_rs1_data;
        w_srcb = w_imm_i;
      end
      OP_STORE: begin
        w_srca       = id_rs1_data;
        w_srcb       = w_imm_s;
        w_store_data = id_rs2_data;
      end
      OP_BRANCH: begin
        w_alu       = ALU_SUB;
        w_srca      = id_rs1_data;
        w_srcb      = id_rs2_data;
        w_is_branch = 1'b1;
      end
      OP_LUI: begin
        w_srcb = w_imm_u;
      end
      OP_AUIPC: begin
        w_srca = id_pc;
        w_srcb = w_imm_u;
      end
      OP_JAL: begin
        w_srca = id_pc;
        w_srcb = 32'd4;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_alu        = ALU_ADD;
      w_srca       = 32'b0;
      w_srcb       = 32'b0;
      w_store_data = 32'b0;
      w_is_branch  = 1'b0;
    end
  end

  // ID/EX register: reset and flush both produce the all-zero bubble, stall holds
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !id_valid)) begin
      r_valid      <= 1'b0;
      r_alucontrol <= ALU_ADD;
      r_srca       <= 32'b0;
      r_srcb       <= 32'b0;
      r_store_data <= 32'b0;
      r_is_branch  <= 1'b0;
      r_funct3     <= 3'b0;
      r_illegal    <= 1'b0;
    end else if (!stall) begin
      r_valid      <= 1'b1;
      r_alucontrol <= w_alu;
      r_srca       <= w_srca;
      r_srcb       <= w_srcb;
      r_store_data <= w_store_data;
      r_is_branch  <= w_is_branch;
      r_funct3     <= w_illegal ? 3'b0 : w_funct3;
      r_illegal    <= w_illegal;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alucontrol = r_alucontrol;
  assign ex_srca       = r_srca;
  assign ex_srcb       = r_srcb;
  assign ex_store_data = r_store_data;
  assign ex_is_branch  = r_is_branch;
  assign ex_funct3     = r_funct3;
  assign ex_illegal    = r_illegal;

endmodule
